// File: rtl/hdmi_color_pkg.sv
// ----------------------------------------------------------------------------
// hdmi_color_pkg
// Shared constants and types for the BT.601 studio-range YCbCr -> full-range
// RGB converter: Q8 coefficients, input offsets, accumulator width, pipeline
// depth and the packed pixel structs.
// ----------------------------------------------------------------------------
package hdmi_color_pkg;

  localparam int CH_W    = 8;   // bits per colour channel
  localparam int ACC_W   = 20;  // signed accumulator / product width
  localparam int LATENCY = 3;   // register stages from input to output

  // Q8 unsigned coefficients, held as signed so products stay signed.
  localparam logic signed [ACC_W-1:0] C_Y  = 20'sd298;
  localparam logic signed [ACC_W-1:0] C_RV = 20'sd409;
  localparam logic signed [ACC_W-1:0] C_GV = 20'sd208;
  localparam logic signed [ACC_W-1:0] C_GU = 20'sd100;
  localparam logic signed [ACC_W-1:0] C_BU = 20'sd516;

  // Rounding term added before the >>>8 (half an LSB of the Q8 result).
  localparam logic signed [ACC_W-1:0] ROUND = 20'sd128;

  // Studio-range offsets for luma and chroma.
  localparam logic [8:0] Y_OFS  = 9'd16;
  localparam logic [8:0] UV_OFS = 9'd128;

  typedef struct packed {
    logic [CH_W-1:0] y;
    logic [CH_W-1:0] u;
    logic [CH_W-1:0] v;
  } yuv_t;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb_t;

  // Zero-extend an 8-bit sample and remove its offset. The result always fits
  // a signed 9-bit value (-128..+239), so no clipping is applied here.
  function automatic logic signed [8:0] offset9(input logic [CH_W-1:0] s,
                                                input logic [8:0]      ofs);
    return signed'({1'b0, s} - ofs);
  endfunction

endpackage

// File: rtl/yuv2rgb_converter_if.sv
// ----------------------------------------------------------------------------
// yuv2rgb_converter_if
// Pixel stream bundle for the converter: YCbCr input side with valid/ready
// and RGB output side with valid/ready, each carrying USER_W sideband bits.
//   slave  : view of the converter (consumes YUV, produces RGB)
//   master : view of the source/sink driving the converter
// ----------------------------------------------------------------------------
interface yuv2rgb_converter_if #(
  parameter int USER_W = 3,
  parameter int BPCH   = 8
);

  // Input side
  logic [BPCH-1:0]   y_i;
  logic [BPCH-1:0]   u_i;
  logic [BPCH-1:0]   v_i;
  logic [USER_W-1:0] user_i;
  logic              valid_i;
  logic              ready_o;

  // Output side
  logic [BPCH-1:0]   r_o;
  logic [BPCH-1:0]   g_o;
  logic [BPCH-1:0]   b_o;
  logic [USER_W-1:0] user_o;
  logic              valid_o;
  logic              ready_i;

  modport slave (
    input  y_i, u_i, v_i, user_i, valid_i, ready_i,
    output ready_o, r_o, g_o, b_o, user_o, valid_o
  );

  modport master (
    output y_i, u_i, v_i, user_i, valid_i, ready_i,
    input  ready_o, r_o, g_o, b_o, user_o, valid_o
  );

endinterface

// File: rtl/clamp_u8.sv
// ----------------------------------------------------------------------------
// clamp_u8
// Combinational saturation of a signed accumulator to an unsigned 8-bit value.
//   acc_i : signed ACC_W-bit input
//   val_o : 0 when acc_i < 0, 255 when acc_i > 255, else acc_i[7:0]
// ----------------------------------------------------------------------------
module clamp_u8
  import hdmi_color_pkg::*;
(
  input  logic signed [ACC_W-1:0] acc_i,
  output logic        [CH_W-1:0]  val_o
);

  always_comb begin
    val_o = acc_i[CH_W-1:0];
    if (acc_i[ACC_W-1]) begin
      val_o = '0;
    end else if (|acc_i[ACC_W-2:CH_W]) begin
      val_o = '1;
    end
  end

endmodule

// File: rtl/yuv2rgb_converter.sv
// ----------------------------------------------------------------------------
// yuv2rgb_converter
// Three-stage BT.601 studio-range YCbCr 4:4:4 -> full-range RGB converter with
// valid/ready flow control and sideband bits carried in lockstep.
//   clk_i  : clock
//   rst_ni : synchronous active-low reset (clears every stage valid bit)
//   bus    : slave view of the pixel stream interface
//            (y/u/v/user/valid in, ready out; r/g/b/user/valid out, ready in)
// Stages: S1 offset subtraction, S2 five dedicated products, S3 sum, round and
// clamp. All stages advance together on en = ready_i | ~valid_o, so the whole
// pipe stalls only when the output holds a sample the sink has not taken.
// ----------------------------------------------------------------------------
module yuv2rgb_converter
  import hdmi_color_pkg::*;
#(
  parameter int USER_W = 3,
  parameter int BPCH   = 8   // only 8 is supported
) (
  input logic                clk_i,
  input logic                rst_ni,
  yuv2rgb_converter_if.slave bus
);

  logic en;

  // --------------------------------------------------------------------------
  // Valid / sideband shift chain. User bits are captured even in bubbles.
  // --------------------------------------------------------------------------
  logic [LATENCY-1:0] valid_d;
  logic [LATENCY-1:0] valid_q;
  logic [USER_W-1:0]  user_d [LATENCY];
  logic [USER_W-1:0]  user_q [LATENCY];

  assign en          = bus.ready_i | ~valid_q[LATENCY-1];
  assign bus.ready_o = en;

  genvar gi;
  generate
    for (gi = 0; gi < LATENCY; gi++) begin : g_ctl
      if (gi == 0) begin : g_head
        assign valid_d[gi] = bus.valid_i;
        assign user_d[gi]  = bus.user_i;
      end else begin : g_tail
        assign valid_d[gi] = valid_q[gi-1];
        assign user_d[gi]  = user_q[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        user_q[i] <= '0;
      end
    end else if (en) begin
      valid_q <= valid_d;
      user_q  <= user_d;
    end
  end

  // --------------------------------------------------------------------------
  // S1: offset removal (no pre-clipping of out-of-range luma)
  // --------------------------------------------------------------------------
  yuv_t                    pix_in;
  logic signed [8:0]       yd_d, ud_d, vd_d;
  logic signed [8:0]       yd_q, ud_q, vd_q;

  assign pix_in = {bus.y_i, bus.u_i, bus.v_i};
  assign yd_d   = offset9(pix_in.y, Y_OFS);
  assign ud_d   = offset9(pix_in.u, UV_OFS);
  assign vd_d   = offset9(pix_in.v, UV_OFS);

  // --------------------------------------------------------------------------
  // S2: five independent products; no multiplier is shared between channels.
  // --------------------------------------------------------------------------
  logic signed [ACC_W-1:0] py_d, prv_d, pgv_d, pgu_d, pbu_d;
  logic signed [ACC_W-1:0] py_q, prv_q, pgv_q, pgu_q, pbu_q;

  assign py_d  = ACC_W'(yd_q) * C_Y;
  assign prv_d = ACC_W'(vd_q) * C_RV;
  assign pgv_d = ACC_W'(vd_q) * C_GV;
  assign pgu_d = ACC_W'(ud_q) * C_GU;
  assign pbu_d = ACC_W'(ud_q) * C_BU;

  // --------------------------------------------------------------------------
  // S3: sum, round, floor shift, saturate. Worst-case magnitudes stay well
  // inside 20 signed bits, so the sums cannot wrap.
  // --------------------------------------------------------------------------
  logic signed [ACC_W-1:0] acc_s3 [3];
  logic        [CH_W-1:0]  sat_s3 [3];
  rgb_t                    rgb_d;
  rgb_t                    rgb_q;

  assign acc_s3[0] = (py_q + prv_q + ROUND) >>> 8;
  assign acc_s3[1] = (py_q - pgv_q - pgu_q + ROUND) >>> 8;
  assign acc_s3[2] = (py_q + pbu_q + ROUND) >>> 8;

  generate
    for (gi = 0; gi < 3; gi++) begin : g_clamp
      clamp_u8 u_clamp (
        .acc_i (acc_s3[gi]),
        .val_o (sat_s3[gi])
      );
    end
  endgenerate

  assign rgb_d = {sat_s3[0], sat_s3[1], sat_s3[2]};

  // --------------------------------------------------------------------------
  // Datapath registers: all hold together when en is low.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      yd_q  <= '0;
      ud_q  <= '0;
      vd_q  <= '0;
      py_q  <= '0;
      prv_q <= '0;
      pgv_q <= '0;
      pgu_q <= '0;
      pbu_q <= '0;
      rgb_q <= '0;
    end else if (en) begin
      yd_q  <= yd_d;
      ud_q  <= ud_d;
      vd_q  <= vd_d;
      py_q  <= py_d;
      prv_q <= prv_d;
      pgv_q <= pgv_d;
      pgu_q <= pgu_d;
      pbu_q <= pbu_d;
      rgb_q <= rgb_d;
    end
  end

  assign bus.r_o     = BPCH'(rgb_q.r);
  assign bus.g_o     = BPCH'(rgb_q.g);
  assign bus.b_o     = BPCH'(rgb_q.b);
  assign bus.user_o  = user_q[LATENCY-1];
  assign bus.valid_o = valid_q[LATENCY-1];

endmodule

// File: doc/yuv2rgb_converter.md
YUV2RGB_CONVERTER -- requirements
Module: yuv2rgb_converter

Interface
REQ-001 Parameter: USER_W, default 3, sideband width carried alongside each pixel ({de, vsync, hsync} for HDMI).
REQ-002 Parameter: BPCH, default 8, bits per channel on input and output; only 8 is supported.
REQ-003 Port: clk_i  input  1  single clock; all logic rises on it.
REQ-004 Port: rst_ni  input  1  reset, synchronous, active-low.
REQ-005 Port: y_i / u_i / v_i  input  BPCH each  studio-range YCbCr 4:4:4 sample.
REQ-006 Port: user_i  input  USER_W  sideband bits, delayed in lockstep with the pixel.
REQ-007 Port: valid_i  input  1  input sample valid.
REQ-008 Port: ready_o  output  1  converter accepts the sample this cycle.
REQ-009 Port: r_o / g_o / b_o  output  BPCH each  full-range RGB result.
REQ-010 Port: user_o  output  USER_W  delayed sideband.
REQ-011 Port: valid_o  output  1  output sample valid.
REQ-012 Port: ready_i  input  1  downstream accepts the output this cycle.

Function
REQ-013 Conversion shall be BT.601 studio-to-full range.
REQ-014 Coefficients shall be Q8 unsigned: C_Y=298, C_RV=409, C_GV=208, C_GU=100, C_BU=516.
REQ-015 Arithmetic shall be as follows, with yd=Y-16, ud=U-128 and vd=V-128 as signed 9-bit values:
- R=(C_Y*yd + C_RV*vd + 128)>>>8
- G=(C_Y*yd - C_GV*vd - C_GU*ud + 128)>>>8
- B=(C_Y*yd + C_BU*ud + 128)>>>8
REQ-016 Accumulators shall be signed 20-bit, the shift arithmetic (floor), and the result clamped: <0 -> 0, >255 -> 255.
REQ-017 Y below 16 or above 235 shall not be pre-clipped; out-of-range values flow through the arithmetic and are clamped only at the output.
REQ-018 The pipeline shall have exactly 3 register stages:
- S1 offset subtraction
- S2 the five products
- S3 sum, round and clamp
REQ-019 Latency with ready_i held high shall be 3 cycles, valid_i to valid_o.
REQ-020 Throughput shall be one sample per cycle.
REQ-021 The global enable shall be en = ready_i | ~valid_o, and ready_o shall equal en combinationally.
REQ-022 When en=0, all stage registers (data, user, valid) shall hold; output data shall remain stable while valid_o=1 and ready_i=0.
REQ-023 A transfer shall occur on valid & ready at each end; no sample is dropped or duplicated under any ready_i pattern.
REQ-024 Bubbles (valid_i=0) shall propagate as invalid stages; data in invalid stages is don't-care, but user bits shall still be captured.
REQ-025 Simultaneous input accept and output transfer in the same cycle shall be legal and shall advance every stage by one.

Reset
REQ-026 When rst_ni=0 at a clk_i edge, all stage valid bits shall clear to 0.
REQ-027 After reset: valid_o=0, r_o=g_o=b_o=0, user_o=0.
REQ-028 During reset, ready_o shall equal 1, following from en.
REQ-029 Reset mid-stream shall discard all in-flight samples; the first accepted sample after reset emerges 3 cycles later.

Structure
REQ-030 Package hdmi_color_pkg shall hold:
- the five Q8 coefficient constants
- offsets 16 and 128
- accumulator width 20
- localparam LATENCY=3
- rgb_t / yuv_t packed struct typedefs (3x8 bits)
REQ-031 Sub-module clamp_u8 (signed 20-bit in -> 8-bit saturated out, combinational) shall be instantiated three times in S3.
REQ-032 No multiplier shall be shared across channels.

Verification
REQ-033 Black: Y=16, U=128, V=128 -> RGB 0,0,0 after 3 cycles with ready_i=1.
REQ-034 White and red:
- Y=235, U=128, V=128 -> 255,255,255
- Y=81, U=90, V=240 -> 255,0,0 (G pre-clamp 0, B pre-clamp -1 clamped)
REQ-035 Saturation: Y=255, U=255, V=255 -> 255,125,255.
REQ-036 Backpressure: stream 16 distinct samples with ready_i toggling pseudo-randomly; outputs shall match a reference model in order, with no loss or duplication, user_o aligned, and data stable while stalled.
REQ-037 Reset mid-stream: drive rst_ni low for 1 cycle with 3 samples in flight -> valid_o=0 the next cycle and none of those samples appear.
